mux16_scan_sampler: RTL

//  Upstream sequencer for the 16:1 bit mux: drives its 4-bit select, waits a fixed

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/scan_dwell_timer.sv | 34 +++
 rtl/mux16_scan_sampler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 16:1 mux scan sampler.
// State encoding, drop counter width and a constant log2 helper.
`timescale 1ns/1ps
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int DROP_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Per-channel dwell counter for the mux scan sampler.
// Ticks on the last dwell cycle; sync clear wins over enable.
`timescale 1ns/1ps
module scan_dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DL = clog2(SETTLE_CYC + 1);
  localparam int DW = (DL > 0) ? DL : 1;
  localparam logic [DW-1:0] LAST = DW'(SETTLE_CYC);

  logic [DW-1:0] dwell;

  assign tick = en & (dwell == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (clr) begin
      dwell <= '0;
    end else if (en) begin
      dwell <= tick ? '0 : dwell + DW'(1);
    end
  end

endmodule

// File: rtl/mux16_scan_sampler.sv
// Scan sequencer for a 16:1 bit mux: steps sel, samples mux_y,
// builds a frame word and offers it on a valid/ready output.
`timescale 1ns/1ps
module mux16_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int SEL_W      = clog2(NUM_CH),
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              overrun,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t state, state_nxt;

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] word;
  logic tmr_en, tmr_clr, tick;
  logic cap, done, flush;
  logic load, drop, consume;

  scan_dwell_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tmr_en),
    .clr  (tmr_clr),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;
    cap       = 1'b0;
    done      = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start && !abort) state_nxt = SCAN;
      end
      SCAN: begin
        if (abort) begin
          flush     = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_en = 1'b1;
          cap    = tick;
          if (tick && sel == LAST_CH) begin
            done = 1'b1;
            if (!continuous) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completed word must include the bit captured this cycle.
  always_comb begin
    word      = acc;
    word[sel] = mux_y;
  end

  assign load    = done & (~frame_valid | frame_ready);
  assign drop    = done & frame_valid & ~frame_ready;
  assign consume = ~done & frame_valid & frame_ready;

  assign busy = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
      acc <= '0;
    end else begin
      if (flush) begin
        sel <= '0;
      end else if (cap) begin
        sel <= sel + SEL_W'(1);
      end
      if (flush || done) begin
        acc <= '0;
      end else if (cap) begin
        acc[sel] <= mux_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      overrun <= 1'b0;
      unique case (1'b1)
        load: begin
          frame       <= word;
          frame_valid <= 1'b1;
        end
        drop: begin
          overrun <= 1'b1;
          if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_W'(1);
        end
        consume: frame_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
